// File: rtl/bcd_share_arbiter.sv
// bcd_share_arbiter
// Four channels share one binary-to-decimal converter. A round-robin search
// picks a requesting channel and latches its value onto conv_in. The value is
// held for SETTLE cycles. The converter result is then stored in that
// channel's result register, and a one-cycle ack pulse is returned.
module bcd_share_arbiter #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [3:0] req,
    input  logic [3:0] val0,
    input  logic [3:0] val1,
    input  logic [3:0] val2,
    input  logic [3:0] val3,
    output logic [3:0] conv_in,
    input  logic [3:0] conv_tens,
    input  logic [3:0] conv_ones,
    output logic [3:0] gnt,
    output logic [3:0] ack,
    output logic [7:0] res0,
    output logic [7:0] res1,
    output logic [7:0] res2,
    output logic [7:0] res3,
    output logic [3:0] res_vld
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACK
    } state_t;

    // Count value on the final settle cycle. Capture happens on that edge.
    localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

    state_t     r_state;
    logic [1:0] r_ptr;       // last acked channel
    logic [1:0] r_ch;        // channel owning the converter
    logic [3:0] r_cnt;       // settle counter
    logic [3:0] r_conv_in;
    logic [3:0] r_gnt;
    logic [3:0] r_ack;
    logic [7:0] r_res [4];
    logic [3:0] r_vld;

    logic [1:0] w_sel;
    logic [1:0] w_idx;
    logic [3:0] w_val;
    logic       w_any;

    assign w_any = |req;

    // Round-robin search: the first requester found at ptr+1, ptr+2, ptr+3, ptr.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        w_sel = r_ptr;
        w_idx = r_ptr;
        // Walk from the farthest candidate back to the nearest so the nearest wins.
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_ptr + 2'(k);
            if (req[w_idx]) begin
                w_sel = w_idx;
            end
        end
    end

    // Select the value of the channel that the search picked.
    always_comb begin
        w_val = val0;
        case (w_sel)
            2'd0:    w_val = val0;
            2'd1:    w_val = val1;
            2'd2:    w_val = val2;
            default: w_val = val3;
        endcase
    end

    // Control FSM. All outputs are registered, and results are stored here.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 2'd3;
            r_ch      <= 2'd0;
            r_cnt     <= 4'd0;
            r_conv_in <= 4'd0;
            r_gnt     <= 4'd0;
            r_ack     <= 4'd0;
            // NOTE: the result array drives outputs that must read zero after reset, so it is reset rather than left as plain storage.
            for (int i = 0; i < 4; i++) begin
                r_res[i] <= 8'd0;
            end
            r_vld     <= 4'd0;
        end else begin
            r_ack <= 4'd0;
            case (r_state)
                ST_IDLE: begin
                    r_gnt <= 4'd0;
                    if (w_any) begin
                        r_ch      <= w_sel;
                        r_conv_in <= w_val;
                        r_gnt     <= 4'b0001 << w_sel;
                        r_cnt     <= 4'd0;
                        r_state   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!req[r_ch]) begin
                        // The requester withdrew. Release the converter without storing a result.
                        r_gnt   <= 4'd0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == LAST_CNT) begin
                        r_res[r_ch] <= {conv_tens, conv_ones};
                        r_vld[r_ch] <= 1'b1;
                        r_ptr       <= r_ch;
                        r_gnt       <= 4'd0;
                        r_ack       <= 4'b0001 << r_ch;
                        r_state     <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= 4'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign conv_in = r_conv_in;
    assign gnt     = r_gnt;
    assign ack     = r_ack;
    assign res0    = r_res[0];
    assign res1    = r_res[1];
    assign res2    = r_res[2];
    assign res3    = r_res[3];
    assign res_vld = r_vld;

endmodule

// File: tb/tb_bcd_share_arbiter.sv
// Directed bench for bcd_share_arbiter. One instance uses SETTLE=1 and one
// uses SETTLE=4. Each instance has a behavioural binary-to-decimal converter.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_bcd_share_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] val [4];

    // SETTLE=1 instance
    logic [3:0] d1_req;
    logic [3:0] d1_conv_in, d1_tens, d1_ones;
    logic [3:0] d1_gnt, d1_ack, d1_vld;
    logic [7:0] d1_res [4];
    logic       d1_frc;
    logic [7:0] d1_frc_val;

    // SETTLE=4 instance
    logic [3:0] d4_req;
    logic [3:0] d4_conv_in, d4_tens, d4_ones;
    logic [3:0] d4_gnt, d4_ack, d4_vld;
    logic [7:0] d4_res [4];

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side scoreboard for the SETTLE=1 instance
    logic [7:0] exp_res [4];
    logic [3:0] exp_vld;

    always #10 clk = ~clk;

    bcd_share_arbiter #(.SETTLE(1)) dut1 (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .req      (d1_req),
        .val0     (val[0]),
        .val1     (val[1]),
        .val2     (val[2]),
        .val3     (val[3]),
        .conv_in  (d1_conv_in),
        .conv_tens(d1_tens),
        .conv_ones(d1_ones),
        .gnt      (d1_gnt),
        .ack      (d1_ack),
        .res0     (d1_res[0]),
        .res1     (d1_res[1]),
        .res2     (d1_res[2]),
        .res3     (d1_res[3]),
        .res_vld  (d1_vld)
    );

    bcd_share_arbiter #(.SETTLE(4)) dut4 (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .req      (d4_req),
        .val0     (val[0]),
        .val1     (val[1]),
        .val2     (val[2]),
        .val3     (val[3]),
        .conv_in  (d4_conv_in),
        .conv_tens(d4_tens),
        .conv_ones(d4_ones),
        .gnt      (d4_gnt),
        .ack      (d4_ack),
        .res0     (d4_res[0]),
        .res1     (d4_res[1]),
        .res2     (d4_res[2]),
        .res3     (d4_res[3]),
        .res_vld  (d4_vld)
    );

    // Converter models. The d1 converter can be forced to an arbitrary digit pair.
    always_comb begin
        if (d1_frc) begin
            d1_tens = d1_frc_val[7:4];
            d1_ones = d1_frc_val[3:0];
        end else if (d1_conv_in >= 4'd10) begin
            d1_tens = 4'd1;
            d1_ones = d1_conv_in - 4'd10;
        end else begin
            d1_tens = 4'd0;
            d1_ones = d1_conv_in;
        end
    end

    always_comb begin
        if (d4_conv_in >= 4'd10) begin
            d4_tens = 4'd1;
            d4_ones = d4_conv_in - 4'd10;
        end else begin
            d4_tens = 4'd0;
            d4_ones = d4_conv_in;
        end
    end

    typedef struct {
        int         ch;
        logic [3:0] v;
        logic       frc;
        logic [7:0] frc_val;
        logic [7:0] exp_r;
        logic [3:0] exp_vld;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_res1(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s res%0d", tag, i), 32'(d1_res[i]), 32'(exp_res[i]));
        end
        check({tag, " res_vld"}, 32'(d1_vld), 32'(exp_vld));
    endtask

    // One full SETTLE=1 transaction on dut1. On entry, req[ch] is already
    // high and the next rising edge samples it. On exit, the FSM has spent
    // one IDLE cycle.
    task automatic serve1(input int ch, input logic [3:0] v, input logic [7:0] r, input string tag);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        tick();
        check({tag, " gnt"}, 32'(d1_gnt), 32'(oh));
        check({tag, " ack_during_gnt"}, 32'(d1_ack), 32'd0);
        check({tag, " conv_in"}, 32'(d1_conv_in), 32'(v));
        tick();
        exp_res[ch] = r;
        exp_vld[ch] = 1'b1;
        check({tag, " gnt_in_ack"}, 32'(d1_gnt), 32'd0);
        check({tag, " ack"}, 32'(d1_ack), 32'(oh));
        check_all_res1(tag);
        d1_req[ch] = 1'b0;
        d1_frc     = 1'b0;
        tick();
        check({tag, " idle_gnt"}, 32'(d1_gnt), 32'd0);
        check({tag, " idle_ack"}, 32'(d1_ack), 32'd0);
    endtask

    initial begin
        vecs[0] = '{ch: 0, v: 4'hC, frc: 1'b0, frc_val: 8'h00, exp_r: 8'h12, exp_vld: 4'b0001};
        vecs[1] = '{ch: 1, v: 4'h7, frc: 1'b0, frc_val: 8'h00, exp_r: 8'h07, exp_vld: 4'b0011};
        vecs[2] = '{ch: 2, v: 4'h9, frc: 1'b0, frc_val: 8'h00, exp_r: 8'h09, exp_vld: 4'b0111};
        vecs[3] = '{ch: 3, v: 4'hF, frc: 1'b0, frc_val: 8'h00, exp_r: 8'h15, exp_vld: 4'b1111};
        vecs[4] = '{ch: 2, v: 4'h0, frc: 1'b0, frc_val: 8'h00, exp_r: 8'h00, exp_vld: 4'b1111};
        vecs[5] = '{ch: 1, v: 4'h5, frc: 1'b1, frc_val: 8'hFA, exp_r: 8'hFA, exp_vld: 4'b1111};
        vecs[6] = '{ch: 3, v: 4'hA, frc: 1'b0, frc_val: 8'h00, exp_r: 8'h10, exp_vld: 4'b1111};

        rst        = 1'b1;
        d1_req     = 4'd0;
        d4_req     = 4'd0;
        d1_frc     = 1'b0;
        d1_frc_val = 8'h00;
        for (int i = 0; i < 4; i++) begin
            val[i]     = 4'd0;
            exp_res[i] = 8'd0;
        end
        exp_vld = 4'd0;

        // Reset state
        tick();
        tick();
        check("rst gnt", 32'(d1_gnt), 32'd0);
        check("rst ack", 32'(d1_ack), 32'd0);
        check("rst conv_in", 32'(d1_conv_in), 32'd0);
        check_all_res1("rst");
        rst = 1'b0;

        // Table of single-request transactions. The first entry is the basic
        // single-request case. A forced converter output checks that results
        // are stored unmodified.
        for (int e = 0; e < 7; e++) begin
            val[vecs[e].ch]    = vecs[e].v;
            d1_req             = 4'b0001 << vecs[e].ch;
            d1_frc             = vecs[e].frc;
            d1_frc_val         = vecs[e].frc_val;
            serve1(vecs[e].ch, vecs[e].v, vecs[e].exp_r, $sformatf("vec%0d", e));
            check($sformatf("vec%0d tbl_vld", e), 32'(d1_vld), 32'(vecs[e].exp_vld));
        end

        // Contention. ptr is 3, so the grant order is 0,1,2,3.
        val[0] = 4'h1; val[1] = 4'h2; val[2] = 4'h3; val[3] = 4'h4;
        d1_req = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            serve1(c, 4'(c + 1), 8'(c + 1), $sformatf("rr%0d", c));
        end

        // Wrap-around fairness. After channel 3, channel 0 goes before channel 3.
        val[0] = 4'h6; val[3] = 4'h8;
        d1_req = 4'b1001;
        serve1(0, 4'h6, 8'h06, "wrap_ch0");
        serve1(3, 4'h8, 8'h08, "wrap_ch3");

        // Input stability. A change on val1 during the grant is ignored.
        val[1] = 4'h7;
        d1_req = 4'b0010;
        tick();
        check("stab gnt", 32'(d1_gnt), 32'b0010);
        check("stab conv_in0", 32'(d1_conv_in), 32'h7);
        val[1] = 4'hF;
        tick();
        check("stab conv_in1", 32'(d1_conv_in), 32'h7);
        check("stab ack", 32'(d1_ack), 32'b0010);
        check("stab res1", 32'(d1_res[1]), 32'h07);
        exp_res[1] = 8'h07;
        d1_req = 4'd0;
        tick();

        // Reset during SETTLE, with res1 holding 05 beforehand.
        val[1] = 4'h5;
        d1_req = 4'b0010;
        serve1(1, 4'h5, 8'h05, "pre_rst");
        d1_req = 4'b0010;
        tick();
        check("midrst gnt_before", 32'(d1_gnt), 32'b0010);
        rst    = 1'b1;
        d1_req = 4'd0;
        tick();
        for (int i = 0; i < 4; i++) exp_res[i] = 8'd0;
        exp_vld = 4'd0;
        check("midrst gnt", 32'(d1_gnt), 32'd0);
        check("midrst ack", 32'(d1_ack), 32'd0);
        check("midrst conv_in", 32'(d1_conv_in), 32'd0);
        check_all_res1("midrst");
        rst    = 1'b0;
        val[0] = 4'h2; val[1] = 4'h3;
        d1_req = 4'b0011;
        serve1(0, 4'h2, 8'h02, "postrst_ch0");
        serve1(1, 4'h3, 8'h03, "postrst_ch1");

        // Abort on the SETTLE=4 instance. First, complete a transaction on channel 1 (ptr becomes 1).
        val[1] = 4'h3;
        d4_req = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("s4 gnt%0d", c), 32'(d4_gnt), 32'b0010);
            check($sformatf("s4 noack%0d", c), 32'(d4_ack), 32'd0);
        end
        tick();
        check("s4 ack", 32'(d4_ack), 32'b0010);
        check("s4 gnt_off", 32'(d4_gnt), 32'd0);
        check("s4 res1", 32'(d4_res[1]), 32'h03);
        check("s4 vld", 32'(d4_vld), 32'b0010);
        d4_req = 4'd0;
        tick();

        val[2] = 4'h9;
        d4_req = 4'b0100;
        tick();
        check("abort gnt_c1", 32'(d4_gnt), 32'b0100);
        tick();
        check("abort gnt_c2", 32'(d4_gnt), 32'b0100);
        check("abort conv_in", 32'(d4_conv_in), 32'h9);
        d4_req = 4'd0;
        tick();
        check("abort gnt_idle", 32'(d4_gnt), 32'd0);
        check("abort ack0", 32'(d4_ack), 32'd0);
        tick();
        check("abort ack1", 32'(d4_ack), 32'd0);
        check("abort res2", 32'(d4_res[2]), 32'h00);
        check("abort res1", 32'(d4_res[1]), 32'h03);
        check("abort vld", 32'(d4_vld), 32'b0010);
        // ptr is still 1, so with req 0101 the search reaches channel 2 before channel 0.
        val[0] = 4'h1;
        d4_req = 4'b0101;
        tick();
        check("abort ptr_gnt", 32'(d4_gnt), 32'b0100);
        d4_req = 4'd0;
        tick();
        check("abort final_gnt", 32'(d4_gnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_share_arbiter.md
BCD_SHARE_ARBITER -- requirements
Module: bcd_share_arbiter

Interface
REQ-001 The block SHALL have one parameter: SETTLE, default 1, the number of cycles (1..15) the shared converter input is held before its result is captured.
REQ-002 The block SHALL have port CLOCK_50, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits, per-channel conversion request; req[i] held high until ack[i] is seen.
REQ-005 The block SHALL have ports val0, val1, val2, val3, input, 4 bits each, channel binary value, stable while the matching req is high.
REQ-006 The block SHALL have port conv_in, output, 4 bits, registered value driven into the shared binary-to-decimal converter.
REQ-007 The block SHALL have ports conv_tens and conv_ones, input, 4 bits each, combinational converter result for conv_in.
REQ-008 The block SHALL have port gnt, output, 4 bits, one-hot or zero, the channel currently owning the converter.
REQ-009 The block SHALL have port ack, output, 4 bits, one-cycle pulse on the channel whose result was just stored.
REQ-010 The block SHALL have ports res0, res1, res2, res3, output, 8 bits each, stored result {tens[3:0], ones[3:0]} per channel.
REQ-011 The block SHALL have port res_vld, output, 4 bits, per-channel flag marking that the result has been stored at least once since reset.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SETTLE and ACK.
REQ-013 In IDLE, when any req bit is high, the block SHALL select the channel i by round-robin search starting at (ptr+1) mod 4, where ptr is the last acked channel.
REQ-014 On that edge it SHALL load conv_in=val_i, set gnt to one-hot i, clear the settle counter and enter SETTLE.
REQ-015 When no req bit is high in IDLE, the block SHALL stay in IDLE with gnt=0 and conv_in unchanged.
REQ-016 conv_in SHALL hold the latched value for the whole grant; changes on val_i during the grant SHALL be ignored.
REQ-017 SETTLE SHALL last exactly SETTLE cycles; on its last edge the block SHALL write res_i={conv_tens,conv_ones}, set res_vld[i], set ptr=i, clear gnt and enter ACK.
REQ-018 ACK SHALL last one cycle with ack[i]=1, then return to IDLE; req is not sampled in ACK.
REQ-019 Latency: with req[i] sampled high at edge N, gnt SHALL be high in cycles N+1..N+SETTLE, ack[i] high in cycle N+SETTLE+1, and IDLE SHALL be reached at N+SETTLE+2.
REQ-020 Abort: if req[i] drops while in SETTLE, the block SHALL return to IDLE on that edge with gnt=0, no ack, res_i/res_vld/ptr unchanged.
REQ-021 At most one gnt bit and at most one ack bit SHALL be high in any cycle; gnt and ack SHALL never be high in the same cycle.
REQ-022 Requests arriving during SETTLE/ACK SHALL be held off (not lost) and arbitrated in the next IDLE.
REQ-023 Wrap-around: a search from ptr=3 SHALL start at channel 0.
REQ-024 Results SHALL be stored unmodified, with no range check; res bits for other channels are never touched.

Reset
REQ-025 When Reset is high at a rising edge, the block SHALL enter IDLE and set gnt=0, ack=0, conv_in=0, res0..res3=0, res_vld=0, ptr=3, settle counter=0.
REQ-026 Reset SHALL take priority over every other event, including mid-SETTLE; an interrupted transaction SHALL produce no ack and no result write.

Verification
REQ-027 The bench SHALL cover single request: SETTLE=1, req=0001, val0=4'hC, converter returns tens=1/ones=2 -> gnt=0001 one cycle, ack=0001 next cycle, res0=8'h12, res_vld=0001.
REQ-028 The bench SHALL cover contention: req=1111 held, each dropped after its ack -> grant order 0,1,2,3; each ack followed by one IDLE cycle before the next gnt.
REQ-029 The bench SHALL cover fairness/wrap: after channel 3 acked, req=1001 -> channel 0 granted first, then 3.
REQ-030 The bench SHALL cover abort: SETTLE=4, req[2] dropped in the 2nd SETTLE cycle -> IDLE, no ack, res2 and res_vld[2] unchanged, ptr unchanged.
REQ-031 The bench SHALL cover reset mid-op: Reset pulsed in SETTLE with prior res1=8'h05 -> all outputs 0, res_vld=0, next request from req=0011 grants channel 0.
REQ-032 The bench SHALL cover input stability: val1 changed from 4'h7 to 4'hF during the grant -> conv_in stays 4'h7 and res1=8'h07.
